ec_point_mult_ctrl: RTL and testbench
=====================================

EC_POINT_MULT_CTRL -- requirements
Module: ec_point_mult_ctrl

Interface
REQ-001 Parameter K_W, default 256: scalar width in bits.
REQ-002 Parameter P_W, default 256: coordinate width; a point is {z,y,x}, 3*P_W bits, x in LSBs; z==0 denotes the point at infinity.
REQ-003 Parameter CONST_TIME, default 0: 1 selects fixed-schedule mode.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 i_clk  in  1  clock.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_p, i_k, i_val / o_rdy  in,in,in/out  3*P_W,K_W,1/1  job request (point, scalar) with valid/ready.
REQ-008 o_p, o_val, o_err / i_rdy  out,out,out/in  3*P_W,1,1/1  result point, valid, error flag, downstream ready.
REQ-009 o_dbl_p, o_dbl_val / i_dbl_rdy  out,out/in  3*P_W,1/1  doubling request to external doubler.
REQ-010 i_dbl_p, i_dbl_err, i_dbl_val / o_dbl_rdy  in,in,in/out  3*P_W,1,1/1  doubler response.
REQ-011 o_add_p1, o_add_p2, o_add_val / i_add_rdy  out,out,out/in  3*P_W,3*P_W,1/1  addition request to external adder.
REQ-012 i_add_p, i_add_err, i_add_val / o_add_rdy  in,in,in/out  3*P_W,1,1/1  adder response.
REQ-013 o_busy  out  1  high in any state other than IDLE.

Function
REQ-014 Algorithm: LSB-first double-and-add; Q (accumulator) starts at infinity (0), N starts at i_p; each iteration i computes N<=2N and, if k[i]==1, Q<=Q+N using pre-doubling N.
REQ-015 States: IDLE, RUN, WAIT, DONE.
REQ-016 IDLE: o_rdy=1; on o_rdy&&i_val, latch i_p into N, i_k into k_rem, clear Q, iteration counter and o_err, go RUN; o_rdy=0 outside IDLE.
REQ-017 RUN (one cycle): terminate to DONE with o_p<=Q, o_val<=1 if CONST_TIME==0 and k_rem==0, or CONST_TIME==1 and counter==K_W; otherwise issue requests and go WAIT.
REQ-018 Issue: always assert o_dbl_val with o_dbl_p=N; assert o_add_val with p1=Q, p2=N when k_rem[0]==1 and Q.z!=0 and not (Q.x==N.x and Q.y==N.y); in CONST_TIME mode assert o_add_val every iteration.
REQ-019 Each *_val SHALL hold with stable data until its ready is sampled high, then deassert next cycle.
REQ-020 WAIT: o_dbl_rdy=o_add_rdy=1; accept each response once; go RUN the cycle after all issued responses are received; shift k_rem right 1, increment counter.
REQ-021 Q update at iteration end: bit==0 -> Q unchanged (add result discarded); bit==1 and Q.z==0 -> Q<=N (pre-doubling); bit==1 and Q==N in x,y -> Q<=doubler result; else Q<=adder result.
REQ-022 Responses may arrive in either order or in the same cycle; both SHALL be captured.
REQ-023 Error: i_dbl_err or i_add_err sampled with its valid -> o_err<=1, o_val<=1, o_p<=0, go DONE; no further requests; later responses accepted and ignored.
REQ-024 DONE: hold o_p/o_val/o_err until i_rdy&&o_val, then o_val<=0, go IDLE; earliest new accept one cycle later.
REQ-025 k=0, CONST_TIME=0: o_val rises 2 cycles after accept cycle with o_p=0, no requests issued.
REQ-026 Counter width $clog2(K_W+1); no wrap.

Reset
REQ-027 Asserting i_rst_n low at any time SHALL immediately force state=IDLE and o_rdy, o_val, o_err, o_busy, o_dbl_val, o_add_val, o_dbl_rdy, o_add_rdy, o_p, Q, N, k_rem, counter to 0; o_rdy=1 from first clock edge after release.
REQ-028 In-flight external responses after reset SHALL be ignored (o_*_rdy=0 in IDLE).

Verification
REQ-029 Stubs: doubler returns {z=1,y=0,x=2x}, adder returns {z=1,y=0,x=x1+x2} mod 2^P_W, latency 3/5 cycles.
REQ-030 k=0, P.x=7, CONST_TIME=0 -> o_p=0, o_val 2 cycles after accept, zero requests.
REQ-031 k=5, P.x=7, CONST_TIME=0 -> o_p.x=35, exactly 3 doubler and 1 adder requests.
REQ-032 k=5, P.x=7, K_W=8, CONST_TIME=1 -> o_p.x=35, exactly 8 doubler and 8 adder requests.
REQ-033 k=3, doubler stub identity (returns input) -> second iteration takes Q==N path, no adder request, o_p.x=P.x.
REQ-034 k=0xFF, i_add_err=1 on first adder response -> o_err=1, o_val=1, o_p=0; hold o_val with i_rdy=0 for 10 cycles, stable.
REQ-035 Reset asserted mid-WAIT, responses delivered after release -> outputs 0, o_rdy=1, next job k=2, P.x=9 -> o_p.x=18.

Source files
------------

// File: rtl/ec_point_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : ec_point_mult_ctrl
// Brief    : LSB-first double-and-add scalar multiplication sequencer that
//            drives an external point doubler and an external point adder.
// Revision : 1.0 - initial release
//==============================================================================
module ec_point_mult_ctrl #(
   parameter int K_W        = 256,
   parameter int P_W        = 256,
   parameter int CONST_TIME = 0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   // job request
   input  logic [3*P_W-1:0]   i_p,
   input  logic [K_W-1:0]     i_k,
   input  logic               i_val,
   output logic               o_rdy,
   // result
   output logic [3*P_W-1:0]   o_p,
   output logic               o_val,
   output logic               o_err,
   input  logic               i_rdy,
   // doubler request / response
   output logic [3*P_W-1:0]   o_dbl_p,
   output logic               o_dbl_val,
   input  logic               i_dbl_rdy,
   input  logic [3*P_W-1:0]   i_dbl_p,
   input  logic               i_dbl_err,
   input  logic               i_dbl_val,
   output logic               o_dbl_rdy,
   // adder request / response
   output logic [3*P_W-1:0]   o_add_p1,
   output logic [3*P_W-1:0]   o_add_p2,
   output logic               o_add_val,
   input  logic               i_add_rdy,
   input  logic [3*P_W-1:0]   i_add_p,
   input  logic               i_add_err,
   input  logic               i_add_val,
   output logic               o_add_rdy,
   output logic               o_busy
);

   localparam int                 c_PT_W    = 3 * P_W;
   localparam int                 c_CNT_W   = $clog2(K_W + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(K_W);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_WAIT = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   logic [1:0]          r_state;
   logic                r_rdy;
   logic                r_val;
   logic                r_err;
   logic [c_PT_W-1:0]   r_p;
   logic [c_PT_W-1:0]   r_q;
   logic [c_PT_W-1:0]   r_n;
   logic [K_W-1:0]      r_k;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_dbl_val;
   logic                r_add_val;
   logic                r_dbl_pend;
   logic                r_add_pend;
   logic [c_PT_W-1:0]   r_dbl_res;
   logic [c_PT_W-1:0]   r_add_res;

   logic                w_q_inf;
   logic                w_q_eq_n;
   logic                w_bit;
   logic                w_add_need;
   logic                w_finish;
   logic                w_dbl_hit;
   logic                w_add_hit;
   logic                w_err_hit;
   logic                w_iter_done;
   logic [c_PT_W-1:0]   w_dbl_res;
   logic [c_PT_W-1:0]   w_add_res;
   logic [c_PT_W-1:0]   w_q_next;

   assign w_q_inf    = (r_q[c_PT_W-1:2*P_W] == '0);
   assign w_q_eq_n   = (r_q[2*P_W-1:0] == r_n[2*P_W-1:0]);
   assign w_bit      = r_k[0];
   // Equal or infinite operands are resolved locally, so the adder is skipped
   // unless fixed-schedule mode demands a request every iteration.
   assign w_add_need = (CONST_TIME != 0) ? 1'b1 : (w_bit && !w_q_inf && !w_q_eq_n);
   assign w_finish   = (CONST_TIME != 0) ? (r_cnt == c_CNT_MAX) : (r_k == '0);

   assign w_dbl_hit   = r_dbl_pend && i_dbl_val;
   assign w_add_hit   = r_add_pend && i_add_val;
   assign w_err_hit   = (w_dbl_hit && i_dbl_err) || (w_add_hit && i_add_err);
   assign w_iter_done = (!r_dbl_pend || w_dbl_hit) && (!r_add_pend || w_add_hit);
   assign w_dbl_res   = w_dbl_hit ? i_dbl_p : r_dbl_res;
   assign w_add_res   = w_add_hit ? i_add_p : r_add_res;

   always_comb begin
      w_q_next = r_q;
      if (w_bit) begin
         if (w_q_inf) begin
            w_q_next = r_n;
         end else if (w_q_eq_n) begin
            w_q_next = w_dbl_res;
         end else begin
            w_q_next = w_add_res;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= c_IDLE;
         r_rdy      <= 1'b0;
         r_val      <= 1'b0;
         r_err      <= 1'b0;
         r_p        <= '0;
         r_q        <= '0;
         r_n        <= '0;
         r_k        <= '0;
         r_cnt      <= '0;
         r_dbl_val  <= 1'b0;
         r_add_val  <= 1'b0;
         r_dbl_pend <= 1'b0;
         r_add_pend <= 1'b0;
         r_dbl_res  <= '0;
         r_add_res  <= '0;
      end else begin
         if (r_dbl_val && i_dbl_rdy) begin
            r_dbl_val <= 1'b0;
         end
         if (r_add_val && i_add_rdy) begin
            r_add_val <= 1'b0;
         end
         case (r_state)
            c_IDLE: begin
               r_rdy <= 1'b1;
               if (r_rdy && i_val) begin
                  r_rdy   <= 1'b0;
                  r_n     <= i_p;
                  r_k     <= i_k;
                  r_q     <= '0;
                  r_cnt   <= '0;
                  r_err   <= 1'b0;
                  r_state <= c_RUN;
               end
            end
            c_RUN: begin
               if (w_finish) begin
                  r_p     <= r_q;
                  r_val   <= 1'b1;
                  r_state <= c_DONE;
               end else begin
                  r_dbl_val  <= 1'b1;
                  r_dbl_pend <= 1'b1;
                  r_add_val  <= w_add_need;
                  r_add_pend <= w_add_need;
                  r_state    <= c_WAIT;
               end
            end
            c_WAIT: begin
               if (w_dbl_hit) begin
                  r_dbl_res  <= i_dbl_p;
                  r_dbl_pend <= 1'b0;
               end
               if (w_add_hit) begin
                  r_add_res  <= i_add_p;
                  r_add_pend <= 1'b0;
               end
               if (w_err_hit) begin
                  r_err      <= 1'b1;
                  r_val      <= 1'b1;
                  r_p        <= '0;
                  r_dbl_val  <= 1'b0;
                  r_add_val  <= 1'b0;
                  r_dbl_pend <= 1'b0;
                  r_add_pend <= 1'b0;
                  r_state    <= c_DONE;
               end else if (w_iter_done) begin
                  r_q <= w_q_next;
                  r_n <= w_dbl_res;
                  r_k <= r_k >> 1;
                  if (r_cnt != c_CNT_MAX) begin
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
                  r_state <= c_RUN;
               end
            end
            c_DONE: begin
               if (r_val && i_rdy) begin
                  r_val   <= 1'b0;
                  r_rdy   <= 1'b1;
                  r_state <= c_IDLE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign o_rdy     = r_rdy;
   assign o_p       = r_p;
   assign o_val     = r_val;
   assign o_err     = r_err;
   assign o_dbl_p   = r_n;
   assign o_dbl_val = r_dbl_val;
   assign o_add_p1  = r_q;
   assign o_add_p2  = r_n;
   assign o_add_val = r_add_val;
   // Stragglers after an abort are drained in DONE; IDLE never accepts.
   assign o_dbl_rdy = (r_state == c_WAIT) || (r_state == c_DONE);
   assign o_add_rdy = (r_state == c_WAIT) || (r_state == c_DONE);
   assign o_busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ec_point_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_ec_point_mult_ctrl
// Brief    : Directed bench for ec_point_mult_ctrl with doubler/adder stubs.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ec_point_mult_ctrl;

   localparam int K_W = 8;
   localparam int P_W = 16;
   localparam int PT  = 3 * P_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   // index 0: variable-time instance, index 1: fixed-schedule instance
   logic [PT-1:0]  in_p [2];
   logic [K_W-1:0] in_k [2];
   logic           in_val [2];
   logic           rdy_i [2];
   logic           out_rdy [2];
   logic [PT-1:0]  out_p [2];
   logic           out_val [2];
   logic           out_err [2];
   logic           busy [2];
   logic [PT-1:0]  dbl_p [2];
   logic           dbl_val [2];
   logic           dbl_rdy_o [2];
   logic [PT-1:0]  add_p1 [2];
   logic [PT-1:0]  add_p2 [2];
   logic           add_val [2];
   logic           add_rdy_o [2];
   logic [PT-1:0]  dbl_rsp_p [2];
   logic           dbl_rsp_val [2];
   logic           dbl_rsp_err [2];
   logic [PT-1:0]  add_rsp_p [2];
   logic           add_rsp_val [2];
   logic           add_rsp_err [2];

   bit dbl_ident   = 1'b0;
   bit add_err_arm = 1'b0;

   ec_point_mult_ctrl #(.K_W(K_W), .P_W(P_W), .CONST_TIME(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_p(in_p[0]), .i_k(in_k[0]), .i_val(in_val[0]), .o_rdy(out_rdy[0]),
      .o_p(out_p[0]), .o_val(out_val[0]), .o_err(out_err[0]), .i_rdy(rdy_i[0]),
      .o_dbl_p(dbl_p[0]), .o_dbl_val(dbl_val[0]), .i_dbl_rdy(1'b1),
      .i_dbl_p(dbl_rsp_p[0]), .i_dbl_err(dbl_rsp_err[0]), .i_dbl_val(dbl_rsp_val[0]),
      .o_dbl_rdy(dbl_rdy_o[0]),
      .o_add_p1(add_p1[0]), .o_add_p2(add_p2[0]), .o_add_val(add_val[0]), .i_add_rdy(1'b1),
      .i_add_p(add_rsp_p[0]), .i_add_err(add_rsp_err[0]), .i_add_val(add_rsp_val[0]),
      .o_add_rdy(add_rdy_o[0]), .o_busy(busy[0])
   );

   ec_point_mult_ctrl #(.K_W(K_W), .P_W(P_W), .CONST_TIME(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_p(in_p[1]), .i_k(in_k[1]), .i_val(in_val[1]), .o_rdy(out_rdy[1]),
      .o_p(out_p[1]), .o_val(out_val[1]), .o_err(out_err[1]), .i_rdy(rdy_i[1]),
      .o_dbl_p(dbl_p[1]), .o_dbl_val(dbl_val[1]), .i_dbl_rdy(1'b1),
      .i_dbl_p(dbl_rsp_p[1]), .i_dbl_err(dbl_rsp_err[1]), .i_dbl_val(dbl_rsp_val[1]),
      .o_dbl_rdy(dbl_rdy_o[1]),
      .o_add_p1(add_p1[1]), .o_add_p2(add_p2[1]), .o_add_val(add_val[1]), .i_add_rdy(1'b1),
      .i_add_p(add_rsp_p[1]), .i_add_err(add_rsp_err[1]), .i_add_val(add_rsp_val[1]),
      .o_add_rdy(add_rdy_o[1]), .o_busy(busy[1])
   );

   function automatic logic [PT-1:0] mkp(input logic [P_W-1:0] x);
      return {{(P_W-1){1'b0}}, 1'b1, {P_W{1'b0}}, x};
   endfunction

   // Stubs: doubler {1,0,2x} after 3 cycles, adder {1,0,x1+x2} after 5 cycles,
   // one-cycle response pulses that are not re-sent if ignored.
   int            dcnt [2];
   int            acnt [2];
   int            n_dbl [2];
   int            n_add [2];
   logic [PT-1:0] dreq [2];
   logic [PT-1:0] areq1 [2];
   logic [PT-1:0] areq2 [2];

   always @(posedge clk) begin
      for (int j = 0; j < 2; j++) begin
         dbl_rsp_val[j] <= 1'b0;
         dbl_rsp_err[j] <= 1'b0;
         add_rsp_val[j] <= 1'b0;
         add_rsp_err[j] <= 1'b0;
         if (dcnt[j] > 0) begin
            dcnt[j] <= dcnt[j] - 1;
            if (dcnt[j] == 1) begin
               dbl_rsp_val[j] <= 1'b1;
               dbl_rsp_p[j]   <= dbl_ident ? dreq[j] : mkp(dreq[j][P_W-1:0] << 1);
            end
         end
         if (acnt[j] > 0) begin
            acnt[j] <= acnt[j] - 1;
            if (acnt[j] == 1) begin
               add_rsp_val[j] <= 1'b1;
               add_rsp_err[j] <= add_err_arm;
               add_rsp_p[j]   <= mkp(areq1[j][P_W-1:0] + areq2[j][P_W-1:0]);
            end
         end
         if (dbl_val[j]) begin
            dreq[j]  <= dbl_p[j];
            dcnt[j]  <= 3;
            n_dbl[j] <= n_dbl[j] + 1;
         end
         if (add_val[j]) begin
            areq1[j] <= add_p1[j];
            areq2[j] <= add_p2[j];
            acnt[j]  <= 5;
            n_add[j] <= n_add[j] + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_job(input int j, input logic [K_W-1:0] k, input logic [P_W-1:0] px,
                          output int lat, output int nd, output int na);
      int d0;
      int a0;
      int g;
      d0 = n_dbl[j];
      a0 = n_add[j];
      in_p[j]   = mkp(px);
      in_k[j]   = k;
      in_val[j] = 1'b1;
      g = 0;
      while (!out_rdy[j] && g < 20) begin
         @(negedge clk);
         g++;
      end
      check("accept_rdy", out_rdy[j], 1);
      @(negedge clk);
      in_val[j] = 1'b0;
      lat = -1;
      for (int c = 1; c <= 500; c++) begin
         if (out_val[j]) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      check("done_in_time", lat > 0, 1);
      nd = n_dbl[j] - d0;
      na = n_add[j] - a0;
   endtask

   task automatic release_job(input int j);
      rdy_i[j] = 1'b1;
      @(negedge clk);
      rdy_i[j] = 1'b0;
      check("release_val", out_val[j], 0);
      check("release_rdy", out_rdy[j], 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int nd;
      int na;
      for (int j = 0; j < 2; j++) begin
         in_p[j]   = '0;
         in_k[j]   = '0;
         in_val[j] = 1'b0;
         rdy_i[j]  = 1'b0;
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rdy", out_rdy[0], 0);
      check("rst_val", out_val[0], 0);
      check("rst_busy", busy[0], 0);
      check("rst_p", out_p[0], 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_rdy0", out_rdy[0], 1);
      check("post_rst_rdy1", out_rdy[1], 1);

      // k=0: immediate result, no external traffic
      run_job(0, 8'd0, 16'd7, lat, nd, na);
      check("k0_latency", lat, 2);
      check("k0_p", out_p[0], 0);
      check("k0_dbl_reqs", nd, 0);
      check("k0_add_reqs", na, 0);
      release_job(0);

      // k=5: 7*5
      run_job(0, 8'd5, 16'd7, lat, nd, na);
      check("k5_p", out_p[0], mkp(16'd35));
      check("k5_err", out_err[0], 0);
      check("k5_dbl_reqs", nd, 3);
      check("k5_add_reqs", na, 1);
      release_job(0);

      // k=5 fixed schedule: all K_W iterations issue both requests
      run_job(1, 8'd5, 16'd7, lat, nd, na);
      check("ct_p", out_p[1], mkp(16'd35));
      check("ct_dbl_reqs", nd, 8);
      check("ct_add_reqs", na, 8);
      release_job(1);

      // identity doubler: second iteration sees Q==N
      dbl_ident = 1'b1;
      run_job(0, 8'd3, 16'd7, lat, nd, na);
      check("eq_p", out_p[0], mkp(16'd7));
      check("eq_dbl_reqs", nd, 2);
      check("eq_add_reqs", na, 0);
      dbl_ident = 1'b0;
      release_job(0);

      // adder error on first adder response
      add_err_arm = 1'b1;
      run_job(0, 8'hFF, 16'd7, lat, nd, na);
      check("err_flag", out_err[0], 1);
      check("err_val", out_val[0], 1);
      check("err_p", out_p[0], 0);
      check("err_add_reqs", na, 1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("err_hold", {out_val[0], out_err[0], out_p[0]}, {1'b1, 1'b1, {PT{1'b0}}});
      end
      add_err_arm = 1'b0;
      release_job(0);

      // reset in WAIT, doubler response lands after release
      in_p[0]   = mkp(16'd7);
      in_k[0]   = 8'hFF;
      in_val[0] = 1'b1;
      @(negedge clk);
      in_val[0] = 1'b0;
      @(negedge clk);
      check("mid_busy", busy[0], 1);
      check("mid_dbl_val", dbl_val[0], 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", busy[0], 0);
      check("async_rst_rdy", out_rdy[0], 0);
      check("async_rst_dbl_p", dbl_p[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("after_rst_val", out_val[0], 0);
      check("after_rst_rdy", out_rdy[0], 1);
      check("after_rst_busy", busy[0], 0);
      check("after_rst_dbl_rdy", dbl_rdy_o[0], 0);
      check("after_rst_p", out_p[0], 0);
      run_job(0, 8'd2, 16'd9, lat, nd, na);
      check("k2_p", out_p[0], mkp(16'd18));
      check("k2_dbl_reqs", nd, 2);
      check("k2_add_reqs", na, 0);
      release_job(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
